// File: rtl/mdu_seq.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer: shift-add multiply, restoring divide, one HI/LO write pulse.
// Optional MDU_EARLY_OUT_EN: multiply stops once the remaining multiplier bits are all zero.
module mdu_seq #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             stall,
   output logic             busy,
   output logic             done,
   output logic             hilo_we,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int unsigned CW  = $clog2(WIDTH + 1);
   localparam int unsigned PW  = 2 * WIDTH;
   localparam int unsigned MSB = WIDTH - 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CALC = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH:0]   acc_q, acc_d;
   logic [WIDTH-1:0] plo_q, plo_d;
   logic [WIDTH-1:0] opd_q, opd_d;
   logic             div_q, div_d;
   logic             sgn_p_q, sgn_p_d;
   logic             sgn_r_q, sgn_r_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;

   // request decode and operand magnitudes
   logic             signed_op, div_op, div0;
   logic [WIDTH-1:0] a_mag, b_mag;

   assign signed_op = ~op[0];
   assign div_op    = op[1];
   assign div0      = div_op & (b == '0);
   assign a_mag     = (signed_op & a[MSB]) ? (~a + WIDTH'(1)) : a;
   assign b_mag     = (signed_op & b[MSB]) ? (~b + WIDTH'(1)) : b;

   // one multiply step: conditional add into the upper accumulator, then shift right
   logic [WIDTH:0]   acc_add;
   logic [PW:0]      mul_sh;
   logic [WIDTH:0]   mul_acc_n;
   logic [WIDTH-1:0] mul_plo_n;

   assign acc_add   = plo_q[0] ? (acc_q + {1'b0, opd_q}) : acc_q;
   assign mul_sh    = {acc_add, plo_q} >> 1;
   assign mul_acc_n = mul_sh[PW:WIDTH];
   assign mul_plo_n = mul_sh[WIDTH-1:0];

   // one divide step: shift remainder/quotient left, subtract when it fits
   logic [WIDTH:0]   rem_sh;
   logic             rem_ge;
   logic [WIDTH:0]   div_acc_n;
   logic [WIDTH-1:0] div_plo_n;

   assign rem_sh    = {acc_q[WIDTH-1:0], plo_q[MSB]};
   assign rem_ge    = rem_sh >= {1'b0, opd_q};
   assign div_acc_n = rem_ge ? (rem_sh - {1'b0, opd_q}) : rem_sh;
   assign div_plo_n = {plo_q[WIDTH-2:0], rem_ge};

   logic [CW-1:0] cnt_inc;
   logic          mul_last;
   logic          last;
   logic [PW-1:0] prod;

   assign cnt_inc = cnt_q + CW'(1);

`ifdef MDU_EARLY_OUT_EN
   // low WIDTH-cnt_inc bits of the shifted register are the multiplier bits still to consume
   assign mul_last = ~div_q & ((mul_plo_n << cnt_inc) == '0);
   assign prod     = {mul_acc_n[WIDTH-1:0], mul_plo_n} >> (CW'(WIDTH) - cnt_inc);
`else
   assign mul_last = 1'b0;
   assign prod     = {mul_acc_n[WIDTH-1:0], mul_plo_n};
`endif

   assign last = (cnt_inc == CW'(WIDTH)) | mul_last;

   // sign-corrected results
   logic [PW-1:0]    prod_fix;
   logic [WIDTH-1:0] quo_fix, rem_fix;

   assign prod_fix = sgn_p_q ? (~prod + PW'(1)) : prod;
   assign quo_fix  = sgn_p_q ? (~div_plo_n + WIDTH'(1)) : div_plo_n;
   assign rem_fix  = sgn_r_q ? (~div_acc_n[WIDTH-1:0] + WIDTH'(1)) : div_acc_n[WIDTH-1:0];

   // next-state and output logic
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      plo_d   = plo_q;
      opd_d   = opd_q;
      div_d   = div_q;
      sgn_p_d = sgn_p_q;
      sgn_r_d = sgn_r_q;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      hi_d    = hi_q;
      lo_d    = lo_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               if (div0) begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
                  hi_d    = a;
                  lo_d    = '1;
               end else begin
                  state_d = S_CALC;
                  busy_d  = 1'b1;
                  cnt_d   = '0;
                  acc_d   = '0;
                  div_d   = div_op;
                  opd_d   = div_op ? b_mag : a_mag;
                  plo_d   = div_op ? a_mag : b_mag;
                  sgn_p_d = signed_op & (a[MSB] ^ b[MSB]);
                  sgn_r_d = signed_op & div_op & a[MSB];
               end
            end
         end
         S_CALC: begin
            cnt_d = cnt_inc;
            acc_d = div_q ? div_acc_n : mul_acc_n;
            plo_d = div_q ? div_plo_n : mul_plo_n;
            if (last) begin
               state_d = S_DONE;
               done_d  = 1'b1;
               if (div_q) begin
                  hi_d = rem_fix;
                  lo_d = quo_fix;
               end else begin
                  hi_d = prod_fix[PW-1:WIDTH];
                  lo_d = prod_fix[WIDTH-1:0];
               end
            end else begin
               busy_d = 1'b1;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         acc_q   <= '0;
         plo_q   <= '0;
         opd_q   <= '0;
         div_q   <= 1'b0;
         sgn_p_q <= 1'b0;
         sgn_r_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         plo_q   <= plo_d;
         opd_q   <= opd_d;
         div_q   <= div_d;
         sgn_p_q <= sgn_p_d;
         sgn_r_q <= sgn_r_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   // stall covers the accepting IDLE cycle combinationally, released in DONE
   assign stall   = (state_q == S_CALC) | ((state_q == S_IDLE) & start);
   assign busy    = busy_q;
   assign done    = done_q;
   assign hilo_we = done_q;
   assign hi      = hi_q;
   assign lo      = lo_q;

endmodule

// File: tb/tb_mdu_seq.sv
// Scoreboard bench for mdu_seq: driver pushes expected {done cycle, hi, lo}; monitor pops on done.
module tb_mdu_seq;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic [1:0]  op = 2'b00;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic        stall, busy, done, hilo_we;
   logic [31:0] hi, lo;

   localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11;

   mdu_seq #(.WIDTH(32)) dut (
      .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
      .stall(stall), .busy(busy), .done(done), .hilo_we(hilo_we), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int total = 0;
   int bad = 0;

   typedef struct {
      int          cyc;
      logic [31:0] hi;
      logic [31:0] lo;
   } exp_t;
   exp_t sb[$];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // expected done cycle relative to the start-sampling cycle
   function automatic int lat(input logic [1:0] o, input logic [31:0] bv);
`ifdef MDU_EARLY_OUT_EN
      logic [31:0] m;
      int          bl;
`endif
      if (o[1] && bv == 32'd0) return 1;
`ifdef MDU_EARLY_OUT_EN
      if (!o[1]) begin
         m  = (o == MULT && bv[31]) ? (~bv + 32'd1) : bv;
         bl = 0;
         for (int i = 0; i < 32; i++) if (m[i]) bl = i + 1;
         return ((bl < 1) ? 1 : bl) + 1;
      end
`endif
      return 33;
   endfunction

   // monitor
   always @(negedge clk) begin
      exp_t e;
      if (done !== 1'b0 || hilo_we !== 1'b0) chk("hilo_we_eq_done", 64'(hilo_we), 64'(done));
      if (done === 1'b1) begin
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_done actual=1 required=0 hi=%h lo=%h cyc=%0d", hi, lo, cyc);
         end else begin
            e = sb.pop_front();
            chk("done_cycle", 64'(cyc), 64'(e.cyc));
            chk("hi", 64'(hi), 64'(e.hi));
            chk("lo", 64'(lo), 64'(e.lo));
         end
      end
   end

   // call at a negedge; leaves start high for the caller to drop
   task automatic issue(input logic [1:0] o, input logic [31:0] av, input logic [31:0] bv,
                        input logic [31:0] eh, input logic [31:0] el, input bit push);
      start = 1'b1;
      op    = o;
      a     = av;
      b     = bv;
      if (push) sb.push_back('{cyc + lat(o, bv), eh, el});
   endtask

   task automatic go(input logic [1:0] o, input logic [31:0] av, input logic [31:0] bv,
                     input logic [31:0] eh, input logic [31:0] el);
      issue(o, av, bv, eh, el, 1'b1);
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
      if (sb.size() != 0) begin
         total++;
         bad++;
         $display("FAIL drain_timeout actual=%0d pending required=0", sb.size());
         sb.delete();
      end
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int l;
      repeat (3) @(negedge clk);
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_done", 64'(done), 64'(0));
      chk("rst_hi", 64'(hi), 64'(0));
      chk("rst_lo", 64'(lo), 64'(0));
      chk("rst_stall", 64'(stall), 64'(0));
      rst = 1'b1;
      @(negedge clk);

      // MULT -3 * 7 with cycle-by-cycle stall/busy
      l = lat(MULT, 32'd7);
      issue(MULT, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b1);
      #1;
      chk("mult_stall_c0", 64'(stall), 64'(1));
      chk("mult_busy_c0", 64'(busy), 64'(0));
      @(negedge clk);
      start = 1'b0;
      for (int k = 1; k <= l; k++) begin
         if (k > 1) @(negedge clk);
         #1;
         chk("mult_stall", 64'(stall), 64'(k < l));
         chk("mult_busy", 64'(busy), 64'(k < l));
      end
      drain();

      go(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001); drain();
      go(DIVU, 32'd7, 32'd2, 32'd1, 32'd3);                                  drain();
      go(DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);          drain();
      go(DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);          drain();
      go(DIV, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD);                  drain();
      go(MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0);         drain();
      go(DIVU, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'hFFFF_FFFF);                 drain();
      go(MULTU, 32'd5, 32'd3, 32'd0, 32'd15);                               drain();
      go(MULTU, 32'd5, 32'd0, 32'd0, 32'd0);                                drain();

      // divide by zero: one-cycle stall, done in cycle 1
      issue(DIV, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b1);
      #1;
      chk("div0_stall_c0", 64'(stall), 64'(1));
      @(negedge clk);
      start = 1'b0;
      #1;
      chk("div0_stall_c1", 64'(stall), 64'(0));
      chk("div0_busy_c1", 64'(busy), 64'(0));
      drain();

      // start pulsed mid-operation is ignored
      issue(DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b1);
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      issue(MULTU, 32'd1, 32'd1, 32'd0, 32'd0, 1'b0);
      @(negedge clk);
      start = 1'b0;
      drain();
      repeat (5) @(negedge clk);

      // reset mid-operation abandons it
      issue(DIVU, 32'd9, 32'd2, 32'd0, 32'd0, 1'b0);
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      #1;
      chk("midrst_busy", 64'(busy), 64'(0));
      chk("midrst_done", 64'(done), 64'(0));
      chk("midrst_hi", 64'(hi), 64'(0));
      chk("midrst_lo", 64'(lo), 64'(0));
      chk("midrst_stall", 64'(stall), 64'(0));

      // start in the first cycle after reset release
      @(negedge clk);
      rst = 1'b1;
      go(MULTU, 32'd6, 32'd7, 32'd0, 32'd42);
      drain();
      repeat (40) @(negedge clk);
      chk("sb_empty", 64'(sb.size()), 64'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mdu_seq.md
Name: mdu_seq

Overview:
- Iterative multiply/divide sequencer replacing the single-cycle combinational mul/div path in the 54-instruction CPU.
- Accepts a MULT/MULTU/DIV/DIVU request from the control unit and runs a WIDTH-step shift-add or restoring-division loop.
- Stalls the PC while it runs.
- Produces one HI/LO write pulse on completion; its hi/lo outputs feed the HI and LO register write muxes.

Parameters:
WIDTH, 32, operand width; iteration count for full-length operations.

Ports:
clk      in   1      clock, rising edge
rst      in   1      synchronous reset, active-low (rst=0 resets at next rising edge)
start    in   1      request; sampled only in IDLE
op       in   2      00 MULT, 01 MULTU, 10 DIV, 11 DIVU
a        in   WIDTH  rs operand; dividend or multiplicand
b        in   WIDTH  rt operand; divisor or multiplier
stall    out  1      hold PC / block RF and HI/LO writes of the current instruction
busy     out  1      registered; high in CALC
done     out  1      registered one-cycle completion pulse
hilo_we  out  1      equals done; write enable for both HI and LO
hi       out  WIDTH  product high word, or remainder
lo       out  WIDTH  product low word, or quotient

Behaviour:
- Reset (rst=0 at a clock edge):
  - state=IDLE.
  - busy, done, hilo_we = 0; hi, lo = 0.
  - Internal accumulators and counter cleared.
  - Applies mid-operation too: the operation is abandoned and no done is issued.
- States: IDLE, CALC, DONE.
- IDLE:
  - start=1 → latch op and operand magnitudes.
  - Signed ops use two's-complement absolute value; unsigned ops take operands as-is.
  - Latch result sign flags:
    - product sign = a[MSB]^b[MSB] for MULT;
    - quotient sign = a[MSB]^b[MSB] for DIV;
    - remainder sign = a[MSB] for DIV.
  - Counter cleared → CALC.
  - Exception: DIV/DIVU with b==0 goes directly to DONE with lo=all-ones, hi=a.
- CALC: one iteration per cycle, counter increments; after WIDTH iterations → DONE.
  - Multiply: if multiplier LSB is set, add multiplicand to the upper accumulator; shift {acc,mplr} right 1.
  - Divide: shift {rem,quo} left 1; if rem>=divisor, subtract and set quo LSB.
  - Width rule: accumulator is WIDTH+1 bits to hold the add carry.
- DONE:
  - hi/lo registered with sign correction applied: negate the 2·WIDTH product; negate quotient; negate remainder.
  - done=hilo_we=1 for exactly this cycle; → IDLE unconditionally.
- Latency: start sampled in cycle 0 → done in cycle WIDTH+1 (cycle 33 at default); divide-by-zero → done in cycle 1.
- stall = (state==CALC) | (state==IDLE & start) | (state==IDLE & start & div-by-zero).
  - stall is low in the DONE cycle, so the instruction retires there.
  - stall is combinational from start.
- Overflow case DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0. Falls out of the magnitude algorithm; no trap.
- start in CALC or DONE: ignored; no queueing.
- hi/lo hold their last result until the next DONE or reset.

Optional Feature:
- Macro: MDU_EARLY_OUT_EN.
- Defined (multiply only): CALC ends after the iteration in which the shifted multiplier magnitude becomes zero, with a minimum of 1 iteration.
  - Remaining shifts are applied in one step, so the result is identical.
  - Done cycle = max(1, bitlength(|b|)) + 1.
  - Divide is unaffected.
- Undefined: always WIDTH iterations.

Test Plan:
- MULT a=0xFFFFFFFD (-3), b=7, start in cycle 0 → stall high cycles 0–32, done/hilo_we only in cycle 33, hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- MULTU a=b=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001; DIVU 7/2 → lo=3, hi=1.
- DIV a=0xFFFFFFF9 (-7), b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIV 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
- DIV a=5, b=0 → done in cycle 1, lo=0xFFFFFFFF, hi=5, stall only in cycle 0.
- Sequence:
  - Start DIVU; pulse start again in cycle 5 → ignored, single done in cycle 33.
  - Start DIVU, then rst=0 in cycle 10 → busy=0, hi=lo=0, no done.
  - Start in the first cycle after rst=1 → accepted normally.
- With MDU_EARLY_OUT_EN: MULTU 5×3 → done in cycle 3, lo=15, hi=0; MULTU 5×0 → done in cycle 2, lo=0. Without the macro, both → done in cycle 33.
